// File: rtl/sos_pkg.sv
// Shared types and constants for the SOS blink-line decoder.
// Parameter sanity is checked once here and enforced at elaboration by sos_detect.
package sos_pkg;

  typedef enum logic [1:0] {
    CLS_S,
    CLS_O,
    CLS_OTHER
  } letter_cls_e;

  localparam int         SO_LEN = 3;
  localparam logic [2:0] S_BITS = 3'b000;
  localparam logic [2:0] O_BITS = 3'b111;

  // Width of the per-letter symbol count and of letter_len.
  localparam int LEN_W = 3;

  function automatic bit params_ok(input int dot_max, input int dash_max,
                                   input int gap_min, input int max_sym,
                                   input int cnt_w);
    bit ok;
    ok = (dot_max >= 1) && (dash_max > dot_max) && (gap_min >= 2);
    ok = ok && (max_sym >= SO_LEN) && (max_sym < (1 << LEN_W));
    ok = ok && (cnt_w >= 2) && (cnt_w <= 30);
    if (ok) begin
      ok = (((1 << cnt_w) - 1) > dash_max) && (((1 << cnt_w) - 1) > gap_min);
    end
    return ok;
  endfunction

endpackage

// File: rtl/sos_detect_run_meter.sv
// Registers the blink line and measures the current run length with a
// saturating counter; flags falling samples and the one-shot letter gap.
module run_meter #(
  parameter int CNT_W   = 8,
  parameter int GAP_MIN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             fall_evt,
  output logic [CNT_W-1:0] high_len,
  output logic             gap_evt
);

  logic             in_q;
  logic [CNT_W-1:0] run_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: sample the line and count samples at the current level.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q    <= 1'b0;
      run_cnt <= '0;
    end else begin
      in_q    <= in;
      run_cnt <= (in != in_q) ? CNT_W'(1) : sat_inc(run_cnt);
    end
  end

  // run_cnt is the length of the run that in_q belongs to, so on the falling
  // sample it is the finished high length; the gap fires on the sample that
  // makes the low run exactly GAP_MIN long, and never again while saturated.
  assign fall_evt = in_q & ~in;
  assign high_len = run_cnt;
  assign gap_evt  = ~in & ~in_q & (run_cnt == CNT_W'(GAP_MIN - 1));

endmodule

// File: rtl/sos_detect.sv
// Classifies blink pulses into dots/dashes, assembles letters and flags the
// S-O-S sequence; every output is registered on the classifying edge.
module sos_detect
  import sos_pkg::*;
#(
  parameter int DOT_MAX  = 1,
  parameter int DASH_MAX = 4,
  parameter int GAP_MIN  = 3,
  parameter int MAX_SYM  = 5,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  output logic               sym_valid,
  output logic               sym_dash,
  output logic               letter_valid,
  output logic [LEN_W-1:0]   letter_len,
  output logic [MAX_SYM-1:0] letter_bits,
  output logic               sos,
  output logic               err
);

  if (!params_ok(DOT_MAX, DASH_MAX, GAP_MIN, MAX_SYM, CNT_W)) begin : g_bad_params
    $error("sos_detect: inconsistent parameters");
  end

  logic             fall_evt;
  logic             gap_evt;
  logic [CNT_W-1:0] high_len;

  run_meter #(
    .CNT_W   (CNT_W),
    .GAP_MIN (GAP_MIN)
  ) u_meter (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .fall_evt (fall_evt),
    .high_len (high_len),
    .gap_evt  (gap_evt)
  );

  logic [MAX_SYM-1:0] acc_bits;
  logic [LEN_W-1:0]   acc_cnt;
  logic               acc_bad;
  letter_cls_e        hist_new;
  letter_cls_e        hist_old;

  function automatic letter_cls_e classify(input logic [LEN_W-1:0] len,
                                           input logic [MAX_SYM-1:0] bits);
    if (len == LEN_W'(SO_LEN) && bits == MAX_SYM'(S_BITS)) return CLS_S;
    if (len == LEN_W'(SO_LEN) && bits == MAX_SYM'(O_BITS)) return CLS_O;
    return CLS_OTHER;
  endfunction

  logic        is_dash;
  logic        too_long;
  logic        acc_full;
  logic        letter_end;
  letter_cls_e new_cls;
  logic        sos_hit;

  always_comb begin
    is_dash    = high_len > CNT_W'(DOT_MAX);
    too_long   = high_len > CNT_W'(DASH_MAX);
    acc_full   = acc_cnt == LEN_W'(MAX_SYM);
    letter_end = gap_evt && ((acc_cnt != '0) || acc_bad);
    new_cls    = classify(acc_cnt, acc_bits);
    sos_hit    = (new_cls == CLS_S) && (hist_old == CLS_S) && (hist_new == CLS_O);
  end

  // Stage p1: symbol/letter decisions land in the output registers. A falling
  // sample and a letter end never coincide, so their branches are exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_valid    <= 1'b0;
      sym_dash     <= 1'b0;
      letter_valid <= 1'b0;
      letter_len   <= '0;
      letter_bits  <= '0;
      sos          <= 1'b0;
      err          <= 1'b0;
      acc_bits     <= '0;
      acc_cnt      <= '0;
      acc_bad      <= 1'b0;
      hist_new     <= CLS_OTHER;
      hist_old     <= CLS_OTHER;
    end else begin
      sym_valid    <= 1'b0;
      letter_valid <= 1'b0;
      sos          <= 1'b0;
      err          <= 1'b0;
      if (fall_evt) begin
        if (too_long) begin
          err      <= 1'b1;
          acc_bits <= '0;
          acc_cnt  <= '0;
          acc_bad  <= 1'b0;
          hist_new <= CLS_OTHER;
          hist_old <= CLS_OTHER;
        end else if (acc_full) begin
          // Overflowing symbols are dropped; the letter will be discarded.
          err     <= 1'b1;
          acc_bad <= 1'b1;
        end else begin
          sym_valid <= 1'b1;
          sym_dash  <= is_dash;
          acc_bits  <= acc_bits | (MAX_SYM'(is_dash) << acc_cnt);
          acc_cnt   <= acc_cnt + LEN_W'(1);
        end
      end else if (letter_end) begin
        if (acc_bad) begin
          hist_new <= CLS_OTHER;
          hist_old <= CLS_OTHER;
        end else begin
          letter_valid <= 1'b1;
          letter_len   <= acc_cnt;
          letter_bits  <= acc_bits;
          sos          <= sos_hit;
          hist_old     <= hist_new;
          hist_new     <= new_cls;
        end
        acc_bits <= '0;
        acc_cnt  <= '0;
        acc_bad  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sos_detect.sv
// Directed-vector bench for sos_detect: drives blink patterns and compares the
// logged symbol/letter/sos/err events against hand-computed expectations.
module tb_sos_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       line;
  logic       sym_valid;
  logic       sym_dash;
  logic       letter_valid;
  logic [2:0] letter_len;
  logic [4:0] letter_bits;
  logic       sos;
  logic       err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sos_detect dut (
    .clk          (clk),
    .rst          (rst),
    .in           (line),
    .sym_valid    (sym_valid),
    .sym_dash     (sym_dash),
    .letter_valid (letter_valid),
    .letter_len   (letter_len),
    .letter_bits  (letter_bits),
    .sos          (sos),
    .err          (err)
  );

  // Event log, written only by the monitor below.
  int   edge_n = 0;
  int   sym_n = 0, let_n = 0, sos_n = 0, err_n = 0, sos_orphan = 0;
  int   sym_edge = -1, let_edge = -1;
  logic dash_log [64];
  int   len_log  [64];
  int   bits_log [64];
  int   sos_log  [64];

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (sym_valid) begin
        if (sym_n < 64) dash_log[sym_n] <= sym_dash;
        sym_n    <= sym_n + 1;
        sym_edge <= edge_n;
      end
      if (letter_valid) begin
        if (let_n < 64) begin
          len_log[let_n]  <= int'(letter_len);
          bits_log[let_n] <= int'(letter_bits);
          sos_log[let_n]  <= int'(sos);
        end
        let_n    <= let_n + 1;
        let_edge <= edge_n;
      end
      if (sos) sos_n <= sos_n + 1;
      if (sos && !letter_valid) sos_orphan <= sos_orphan + 1;
      if (err) err_n <= err_n + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v);
    line = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  task automatic letter_s();
    pulse(1, 1); pulse(1, 1); pulse(1, 3);
  endtask

  task automatic letter_o();
    pulse(3, 1); pulse(3, 1); pulse(3, 3);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step(1'b0);
    chk({tag, "_rst_sym_valid"}, int'(sym_valid), 0);
    chk({tag, "_rst_letter_len"}, int'(letter_len), 0);
    chk({tag, "_rst_letter_bits"}, int'(letter_bits), 0);
    chk({tag, "_rst_flags"}, int'({letter_valid, sos, err, sym_dash}), 0);
    rst = 1'b0;
  endtask

  int b_sym, b_let, b_sos, b_err, pat, e0;

  task automatic mark();
    b_sym = sym_n; b_let = let_n; b_sos = sos_n; b_err = err_n;
  endtask

  initial begin
    rst  = 1'b1;
    line = 1'b0;
    step(1'b0);
    do_reset("t0");

    // 1: S, O, S
    mark();
    letter_s(); letter_o(); letter_s();
    repeat (4) step(1'b0);
    chk("t1_sym_count", sym_n - b_sym, 9);
    pat = 0;
    for (int i = 0; i < 9; i++) pat = (pat << 1) | int'(dash_log[b_sym + i]);
    chk("t1_dash_pattern", pat, 9'b000111000);
    chk("t1_letter_count", let_n - b_let, 3);
    chk("t1_l0_len", len_log[b_let], 3);
    chk("t1_l0_bits", bits_log[b_let], 0);
    chk("t1_l1_bits", bits_log[b_let + 1], 7);
    chk("t1_l2_len_bits", len_log[b_let + 2] * 100 + bits_log[b_let + 2], 300);
    chk("t1_sos_per_letter", sos_log[b_let] * 4 + sos_log[b_let + 1] * 2 + sos_log[b_let + 2], 1);
    chk("t1_sos_count", sos_n - b_sos, 1);
    chk("t1_err_count", err_n - b_err, 0);

    // 2: high runs 1,2,4,5 -> dot, dash, dash, error
    do_reset("t2");
    mark();
    pulse(1, 1); pulse(2, 1); pulse(4, 1); pulse(5, 3);
    repeat (4) step(1'b0);
    chk("t2_sym_count", sym_n - b_sym, 3);
    pat = 0;
    for (int i = 0; i < 3; i++) pat = (pat << 1) | int'(dash_log[b_sym + i]);
    chk("t2_dash_pattern", pat, 3'b011);
    chk("t2_err_count", err_n - b_err, 1);
    chk("t2_letter_count", let_n - b_let, 0);

    // 3: six dots overflow the letter
    do_reset("t3");
    mark();
    repeat (5) pulse(1, 1);
    pulse(1, 3);
    repeat (4) step(1'b0);
    chk("t3_sym_count", sym_n - b_sym, 5);
    chk("t3_err_count", err_n - b_err, 1);
    chk("t3_letter_count", let_n - b_let, 0);
    chk("t3_sos_count", sos_n - b_sos, 0);

    // 4: reset mid-letter discards the partial letter
    do_reset("t4");
    pulse(1, 1); pulse(1, 1);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    mark();
    pulse(1, 3);
    repeat (4) step(1'b0);
    chk("t4_sym_count", sym_n - b_sym, 1);
    chk("t4_letter_count", let_n - b_let, 1);
    chk("t4_len", len_log[b_let], 1);
    chk("t4_bits", bits_log[b_let], 0);

    // 5a: E, S, O, S -> sos only on the last letter
    do_reset("t5");
    mark();
    pulse(1, 3); letter_s(); letter_o(); letter_s();
    repeat (4) step(1'b0);
    chk("t5a_letter_count", let_n - b_let, 4);
    chk("t5a_sos_per_letter",
        sos_log[b_let] * 8 + sos_log[b_let + 1] * 4 + sos_log[b_let + 2] * 2 + sos_log[b_let + 3], 1);
    chk("t5a_sos_count", sos_n - b_sos, 1);
    // 5b: S, O, over-long pulse, S -> history wiped, no sos
    mark();
    letter_s(); letter_o(); pulse(5, 3); letter_s();
    repeat (4) step(1'b0);
    chk("t5b_letter_count", let_n - b_let, 3);
    chk("t5b_err_count", err_n - b_err, 1);
    chk("t5b_sos_count", sos_n - b_sos, 0);

    // 6: line high across reset release, then a long idle
    rst  = 1'b1;
    step(1'b1);
    e0 = edge_n;
    rst = 1'b0;
    mark();
    step(1'b1);
    repeat (300) step(1'b0);
    chk("t6_sym_count", sym_n - b_sym, 1);
    chk("t6_sym_dash", int'(dash_log[b_sym]), 0);
    chk("t6_sym_edge", sym_edge - e0, 2);
    chk("t6_letter_count", let_n - b_let, 1);
    chk("t6_letter_edge", let_edge - e0, 4);
    chk("t6_len_bits", len_log[b_let] * 100 + bits_log[b_let], 100);
    chk("t6_err_count", err_n - b_err, 0);

    chk("sos_without_letter", sos_orphan, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
